// File: rtl/mem_access_sequencer.sv
// Multicycle load/store sequencer between the MEM stage and a single-port word memory.
// Optional mem_ack timeout abort is built when MEMSEQ_TIMEOUT_EN is defined.
module mem_access_sequencer #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int TIMEOUT    = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [2:0]            req_funct3,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_misaligned,
    output logic                  resp_error,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_ack,
    output logic                  busy
);

    // state    | meaning
    // ST_IDLE  | ready for a request
    // ST_READ  | word read in flight (load, or first half of sub-word store)
    // ST_WRITE | full merged word write in flight
    // ST_RESP  | one-cycle response pulse
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    function automatic logic is_misaligned(input logic wr, input logic [2:0] f3,
                                           input logic [1:0] a);
        logic m;
        case (f3)
            F3_B:    m = 1'b0;
            F3_H:    m = a[0];
            F3_W:    m = (a != 2'b00);
            F3_BU:   m = wr;
            F3_HU:   m = wr | a[0];
            default: m = 1'b1;
        endcase
        return m;
    endfunction

    function automatic logic [31:0] extract(input logic [31:0] word, input logic [2:0] f3,
                                            input logic [1:0] a);
        logic [31:0] shifted;
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        shifted = word >> {a, 3'b000};
        b       = shifted[7:0];
        h       = a[1] ? word[31:16] : word[15:0];
        case (f3)
            F3_B:    r = {{24{b[7]}}, b};
            F3_BU:   r = {24'h000000, b};
            F3_H:    r = {{16{h[15]}}, h};
            F3_HU:   r = {16'h0000, h};
            default: r = word;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] word, input logic [2:0] f3,
                                          input logic [1:0] a, input logic [15:0] wd);
        logic [31:0] mask;
        logic [31:0] r;
        mask = 32'h0000_00FF << {a, 3'b000};
        case (f3)
            F3_B:    r = (word & ~mask) | ({24'h000000, wd[7:0]} << {a, 3'b000});
            F3_H:    r = a[1] ? {wd, word[15:0]} : {word[31:16], wd};
            default: r = word;
        endcase
        return r;
    endfunction

    state_t                state_q, state_d;
    logic                  write_q, write_d;
    logic [2:0]            funct3_q, funct3_d;
    logic [1:0]            addr_lo_q, addr_lo_d;
    logic [15:0]           wdata_lo_q, wdata_lo_d;
    logic                  req_ready_q, req_ready_d;
    logic                  busy_q, busy_d;
    logic                  mem_en_q, mem_en_d;
    logic                  mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
    logic                  resp_valid_q, resp_valid_d;
    logic [DATA_WIDTH-1:0] resp_rdata_q, resp_rdata_d;
    logic                  resp_mis_q, resp_mis_d;

`ifdef MEMSEQ_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             resp_err_q, resp_err_d;
    logic             timeout_hit;
    assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT - 1));
`endif

    always_comb begin
        state_d      = state_q;
        write_d      = write_q;
        funct3_d     = funct3_q;
        addr_lo_d    = addr_lo_q;
        wdata_lo_d   = wdata_lo_q;
        req_ready_d  = req_ready_q;
        busy_d       = busy_q;
        mem_en_d     = mem_en_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        resp_valid_d = 1'b0;
        resp_rdata_d = resp_rdata_q;
        resp_mis_d   = resp_mis_q;
`ifdef MEMSEQ_TIMEOUT_EN
        resp_err_d   = resp_err_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    write_d     = req_write;
                    funct3_d    = req_funct3;
                    addr_lo_d   = req_addr[1:0];
                    wdata_lo_d  = req_wdata[15:0];
                    req_ready_d = 1'b0;
                    busy_d      = 1'b1;
                    if (is_misaligned(req_write, req_funct3, req_addr[1:0])) begin
                        state_d      = ST_RESP;
                        resp_valid_d = 1'b1;
                        resp_mis_d   = 1'b1;
                        resp_rdata_d = '0;
                    end else begin
                        mem_en_d   = 1'b1;
                        mem_addr_d = {req_addr[ADDR_WIDTH-1:2], 2'b00};
                        if (req_write && req_funct3 == F3_W) begin
                            state_d     = ST_WRITE;
                            mem_we_d    = 1'b1;
                            mem_wdata_d = req_wdata;
                        end else begin
                            state_d  = ST_READ;
                            mem_we_d = 1'b0;
                        end
                    end
                end
            end
            ST_READ: begin
                if (mem_ack) begin
                    if (write_q) begin
                        state_d     = ST_WRITE;
                        mem_we_d    = 1'b1;
                        mem_wdata_d = merge(mem_rdata, funct3_q, addr_lo_q, wdata_lo_q);
                    end else begin
                        state_d      = ST_RESP;
                        mem_en_d     = 1'b0;
                        resp_valid_d = 1'b1;
                        resp_rdata_d = extract(mem_rdata, funct3_q, addr_lo_q);
                    end
                end
`ifdef MEMSEQ_TIMEOUT_EN
                else if (timeout_hit) begin
                    state_d      = ST_RESP;
                    mem_en_d     = 1'b0;
                    resp_valid_d = 1'b1;
                    resp_rdata_d = '0;
                    resp_err_d   = 1'b1;
                end
`endif
            end
            ST_WRITE: begin
                if (mem_ack) begin
                    state_d      = ST_RESP;
                    mem_en_d     = 1'b0;
                    mem_we_d     = 1'b0;
                    resp_valid_d = 1'b1;
                    resp_rdata_d = '0;
                end
`ifdef MEMSEQ_TIMEOUT_EN
                else if (timeout_hit) begin
                    state_d      = ST_RESP;
                    mem_en_d     = 1'b0;
                    mem_we_d     = 1'b0;
                    resp_valid_d = 1'b1;
                    resp_rdata_d = '0;
                    resp_err_d   = 1'b1;
                end
`endif
            end
            default: begin
                state_d      = ST_IDLE;
                req_ready_d  = 1'b1;
                busy_d       = 1'b0;
                resp_rdata_d = '0;
                resp_mis_d   = 1'b0;
`ifdef MEMSEQ_TIMEOUT_EN
                resp_err_d   = 1'b0;
`endif
            end
        endcase
`ifdef MEMSEQ_TIMEOUT_EN
        // Staying in READ/WRITE means no ack this cycle; any transition restarts the count.
        if ((state_q == ST_READ || state_q == ST_WRITE) && state_d == state_q)
            cnt_d = cnt_q + 1'b1;
        else
            cnt_d = '0;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            write_q      <= 1'b0;
            funct3_q     <= 3'b000;
            addr_lo_q    <= 2'b00;
            wdata_lo_q   <= '0;
            req_ready_q  <= 1'b1;
            busy_q       <= 1'b0;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_mis_q   <= 1'b0;
`ifdef MEMSEQ_TIMEOUT_EN
            resp_err_q   <= 1'b0;
            cnt_q        <= '0;
`endif
        end else begin
            state_q      <= state_d;
            write_q      <= write_d;
            funct3_q     <= funct3_d;
            addr_lo_q    <= addr_lo_d;
            wdata_lo_q   <= wdata_lo_d;
            req_ready_q  <= req_ready_d;
            busy_q       <= busy_d;
            mem_en_q     <= mem_en_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_mis_q   <= resp_mis_d;
`ifdef MEMSEQ_TIMEOUT_EN
            resp_err_q   <= resp_err_d;
            cnt_q        <= cnt_d;
`endif
        end
    end

    assign req_ready       = req_ready_q;
    assign busy            = busy_q;
    assign mem_en          = mem_en_q;
    assign mem_we          = mem_we_q;
    assign mem_addr        = mem_addr_q;
    assign mem_wdata       = mem_wdata_q;
    assign resp_valid      = resp_valid_q;
    assign resp_rdata      = resp_rdata_q;
    assign resp_misaligned = resp_mis_q;
`ifdef MEMSEQ_TIMEOUT_EN
    assign resp_error      = resp_err_q;
`else
    assign resp_error      = 1'b0;
`endif

endmodule

// File: doc/mem_access_sequencer.md
Name: mem_access_sequencer

Overview:
- Multicycle load/store sequencer between the pipeline MEM stage and a single-port, word-addressed data memory with a req/ack handshake.
- Accepts one access at a time and does word-aligned reads.
- Sub-word stores are done as read-modify-write. Load results are sign- or zero-extended.
- Misaligned or illegal accesses are rejected without touching memory.

Parameters:
- DATA_WIDTH, 32, data word width (fixed at 32; byte-lane logic assumes 4 lanes)
- ADDR_WIDTH, 32, byte address width
- TIMEOUT, 16, cycles to wait for mem_ack before abort (used only with MEMSEQ_TIMEOUT_EN)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  access request
- req_ready  out  1  high only in IDLE
- req_write  in  1  1=store, 0=load
- req_funct3  in  3  000 b, 001 h, 010 w, 100 bu, 101 hu
- req_addr  in  ADDR_WIDTH  byte address
- req_wdata  in  DATA_WIDTH  store data, right-justified
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  DATA_WIDTH  extended load data; 0 for stores and errors
- resp_misaligned  out  1  qualifies resp_valid: access rejected
- resp_error  out  1  qualifies resp_valid: memory timeout
- mem_en  out  1  memory request
- mem_we  out  1  write strobe
- mem_addr  out  ADDR_WIDTH  {req_addr[ADDR_WIDTH-1:2],2'b00}
- mem_wdata  out  DATA_WIDTH  full merged word
- mem_rdata  in  DATA_WIDTH  read word, valid with mem_ack
- mem_ack  in  1  completes current mem_en cycle; may be high in the first mem_en cycle
- busy  out  1  state != IDLE

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE.
  - All outputs are 0 except req_ready=1.
  - All latched request fields clear.
  - mem_en drops immediately, even mid-access. An in-flight write may be lost; no response is issued for it.
- Handshake: a request is accepted when req_valid && req_ready at a clock edge. All req_* fields are latched. Inputs are don't-care after acceptance.
- Error check at accept. An access is misaligned when:
  - funct3 is h/hu and addr[0]=1, or
  - funct3 is w and addr[1:0]!=0, or
  - funct3 is 011/110/111, or
  - it is a store with funct3 100/101.
- Shift amount: sh = addr[1:0]*8.
- States:
  - IDLE: req_ready=1. On accept:
    - misaligned -> RESP with resp_misaligned set.
    - store w -> WRITE with merged = req_wdata.
    - otherwise -> READ.
  - READ: mem_en=1, mem_we=0, held until mem_ack. On ack, mem_rdata is captured.
    - Load -> RESP with extracted data.
    - Store -> WRITE with merged word.
  - WRITE: mem_en=1, mem_we=1, mem_wdata=merged, held stable until mem_ack. On ack -> RESP.
  - RESP: resp_valid=1 for exactly one cycle, resp_* registered. Next state is IDLE. A new request is accepted the following cycle, so there is no back-to-back overlap.
- Merge:
  - sb: replace byte lane sh with wdata[7:0].
  - sh: replace lanes addr[1]*16 +: 16 with wdata[15:0].
- Extract:
  - b/bu: byte at lane sh, sign- or zero-extended to 32.
  - h/hu: halfword at addr[1]*16, sign- or zero-extended to 32.
  - w: full word.
- Latency from accept edge to resp_valid, with zero-wait ack:
  - Misaligned: 1 cycle.
  - Load / sw: 2 cycles.
  - sb/sh: 3 cycles.
  - Each wait cycle adds 1.
- mem_ack outside READ/WRITE is ignored.
- mem_addr and mem_wdata hold their last value while mem_en=0 (don't-care).

Optional Feature:
- MEMSEQ_TIMEOUT_EN defined:
  - A counter clears on entry to READ/WRITE and increments each cycle without mem_ack.
  - When it reaches TIMEOUT-1 with no ack, mem_en drops, state goes to RESP with resp_error=1 and resp_rdata=0.
  - A store aborted in READ never writes.
- MEMSEQ_TIMEOUT_EN undefined: waits indefinitely, resp_error is tied 0, no counter logic.

Test Plan:
- lw at 0x100, memory 0x80FF1234, ack in first cycle -> resp_valid 2 cycles after accept, rdata=0x80FF1234.
- Memory word 0x80FF0000 at 0x200:
  - lb 0x203 -> 0xFFFFFF80.
  - lbu 0x203 -> 0x00000080.
  - lh 0x202 -> 0xFFFF80FF.
  - lhu 0x202 -> 0x000080FF.
- Memory word 0x11223344:
  - sb addr 0x2 wdata 0xAB -> one read, then write 0x11AB3344, resp after 3 cycles.
  - sh addr 0x2 wdata 0xBEEF -> write 0xBEEF3344.
- lw at 0x101, sh at 0x3, funct3=011 -> each gives resp_misaligned=1 one cycle after accept, mem_en never asserted.
- sw with mem_ack delayed 5 cycles -> mem_we/mem_wdata stable throughout, req_ready=0 until after the resp pulse. rst_n pulled low mid-WRITE -> mem_en=0 immediately, no resp, req_ready=1.
- MEMSEQ_TIMEOUT_EN, TIMEOUT=16, mem_ack never asserted on lw -> resp_error=1 with rdata=0 after 16 mem_en cycles, then IDLE.
